cache_mem_responder: RTL
========================

# cache_mem_responder

Main-memory responder for the 4-way set-associative cache: the far end of the cache's line-fill / write-back interface. Accepts one line-granular read or write request at a time, holds it for a fixed, parameterised latency, then returns a one-cycle response strobe with the line data. It serves as the backing store for cache simulation and integration, so miss, fill and write-back paths run against a realistic multi-cycle memory.

## Interface
- LINE_W, 128, bits per cache line
- DEPTH_LOG2, 8, log2 of stored lines; array holds 2^DEPTH_LOG2 lines
- ADDR_W, 16, width of line address (ADDR_W >= DEPTH_LOG2)
- LATENCY, 4, clock edges from request sample to response; legal range 1..255

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_mem_req  in  1  request valid; sampled only while o_mem_busy = 0
- i_mem_rw  in  1  1 = write line, 0 = read line
- i_mem_addr  in  ADDR_W  line address; only bits [DEPTH_LOG2-1:0] index the array
- i_mem_line  in  LINE_W  write data, sampled with the request
- o_mem_busy  out  1  high whenever a request is outstanding (state != IDLE)
- o_memory_response  out  1  one-cycle completion strobe
- o_memory_line  out  LINE_W  read data (read) or committed write data (write); valid while o_memory_response = 1, held until the next response

## Operation
- State machine, three states: IDLE, WAIT, RESP.
- IDLE: busy = 0. On i_mem_req = 1, capture rw, addr[DEPTH_LOG2-1:0] and line; load cnt = LATENCY-1; go to WAIT.
- WAIT: busy = 1. If cnt = 0, go to RESP, otherwise cnt <= cnt-1. All inputs ignored.
- Transition WAIT->RESP (same edge):
  - read: o_memory_line <= mem[idx]
  - write: mem[idx] <= captured line and o_memory_line <= captured line
- RESP: o_memory_response = 1, busy = 1, for exactly one cycle; then go to IDLE. i_mem_req during RESP is ignored, not queued.
- Upper address bits [ADDR_W-1:DEPTH_LOG2] are ignored, so addresses equal modulo 2^DEPTH_LOG2 alias to the same line.
- Array contents are not reset; a line is X until first written. Reset never clears the array.
- Reset asserted mid-transaction aborts it:
  - state forced to IDLE; no response issued
  - a write aborted before its WAIT->RESP edge is never committed
- Only one transaction is outstanding at a time; there is no queue.

## Timing
- Reset values: o_mem_busy = 0, o_memory_response = 0, o_memory_line = 0, state = IDLE, cnt = 0.
- Request sampled at edge E0. o_mem_busy is high from after E0 through the RESP cycle.
- WAIT->RESP occurs at edge E0+LATENCY, so o_memory_response is high during the cycle after E0+LATENCY.
- RESP->IDLE occurs at E0+LATENCY+1; the earliest next request is sampled at E0+LATENCY+2. Back-to-back throughput is one request per LATENCY+2 cycles.
- LATENCY = 1: WAIT lasts one cycle with cnt = 0; the response follows the edge after the request.
- Read-after-write to the same index always returns the new data, since the write commits before the read can be sampled.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst = 0 for 2 cycles, release -> busy = 0, response = 0, o_memory_line = 0; no response for 20 idle cycles.
- Write then read (LATENCY = 4): write addr 0x0012, data 0x0123…CDEF -> response exactly 4 edges after the request sample, busy high 5 cycles. Read 0x0012 -> same data, response 4 edges after its request.
- Busy rejection: assert i_mem_req with addr 0x0005 during WAIT and during RESP -> exactly one response, for the original request only; the array at 0x0005 is unchanged.
- Aliasing (DEPTH_LOG2 = 8): write 0xAAAA… to addr 0x0103, read addr 0x0003 -> returns 0xAAAA….
- Reset mid-write: write 0x5555… to addr 0x0020, pull rst low 2 cycles after the request, then read addr 0x0020 -> prior contents (0x1111… preloaded earlier), and no response for the aborted write.
- LATENCY = 1 back-to-back: 8 consecutive reads issued as soon as busy drops -> each response 1 edge after its request, 3-cycle request spacing, data matches the preloaded pattern.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Line-granular main-memory model behind the cache fill/write-back port.
// One request at a time, answered LATENCY edges after it is sampled.
module cache_mem_responder #(
   parameter int LINE_W     = 128,
   parameter int DEPTH_LOG2 = 8,
   parameter int ADDR_W     = 16,
   parameter int LATENCY    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mem_req,
   input  logic              i_mem_rw,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [LINE_W-1:0] i_mem_line,
   output logic              o_mem_busy,
   output logic              o_memory_response,
   output logic [LINE_W-1:0] o_memory_line
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [7:0]              cnt;
   logic                    accept;
   logic                    commit;

   logic                    rw_p0;
   logic [DEPTH_LOG2-1:0]   idx_p0;
   logic [LINE_W-1:0]       line_p0;

   logic [LINE_W-1:0]       mem [0:DEPTH-1];

   // Upper line-address bits alias onto the same storage line.
   generate
      if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^i_mem_addr[ADDR_W-1:DEPTH_LOG2];
      end
   endgenerate

   assign accept = (state == IDLE) && i_mem_req;
   assign commit = (state == WAIT) && (cnt == 8'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_mem_req) state_nxt = WAIT;
         WAIT:    if (cnt == 8'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_mem_busy        = (state != IDLE);
      o_memory_response = (state == RESP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 8'd0;
      end else if (accept) begin
         cnt <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 8'd0)) begin
         cnt <= cnt - 8'd1;
      end
   end

   // Request capture stage: held stable for the whole WAIT period.
   always_ff @(posedge clk) begin
      if (accept) begin
         rw_p0   <= i_mem_rw;
         idx_p0  <= i_mem_addr[DEPTH_LOG2-1:0];
         line_p0 <= i_mem_line;
      end
   end

   // Commit stage: state is forced to IDLE by reset, so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (commit && rw_p0) begin
         mem[idx_p0] <= line_p0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_memory_line <= '0;
      end else if (commit) begin
         o_memory_line <= rw_p0 ? line_p0 : mem[idx_p0];
      end
   end

endmodule
